kbd_scan_encoder: RTL and testbench

- Scans a 4x4 active-low matrix keypad and debounces each press.
- Encodes the pressed key into the 4-bit keyboard code consumed by downstream kbd[1..4]-style inputs.
- It is the producer end of the keyboard nibble interface: it drives the code plus a valid/ack handshake toward the logic that reads the keyboard.

---
 rtl/kbd_scan_encoder.sv | 175 +++++++++++++++++
 tb/tb_kbd_scan_encoder.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kbd_scan_encoder.sv
// kbd_scan_encoder: 4x4 active-low keypad scanner with press/release
// debounce, producing a 4-bit key code (row*4 + col) with a valid/ack
// handshake toward the keyboard consumer.
// Optional build macro KBD_REPEAT_EN: while a key stays held, the code is
// re-offered every 16*SCAN_DIV clocks (same overrun rule as a fresh press).
module kbd_scan_encoder #(
  parameter int SCAN_DIV   = 16,
  parameter int DEB_CYCLES = 8,
  parameter int CNT_W      = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [3:0] row_n,
  input  logic [3:0] col_n,
  output logic [3:0] kbd,
  output logic       kbd_valid,
  input  logic       kbd_ack,
  output logic       key_down
);

  typedef enum logic [1:0] {
    SCAN        = 2'd0,
    DEB_PRESS   = 2'd1,
    HELD        = 2'd2,
    DEB_RELEASE = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_e           state_q;
  logic [CNT_W-1:0] scan_cnt_q;
  logic [CNT_W-1:0] deb_cnt_q;
  logic [3:0]       row_n_q;
  logic [3:0]       cand_q;     // {row index, column} latched at detection
  logic [3:0]       kbd_q;
  logic             valid_q;
  logic             key_down_q;

`ifdef KBD_REPEAT_EN
  localparam int             REP_W    = $clog2(16 * SCAN_DIV);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(16 * SCAN_DIV - 1);
  localparam logic [REP_W-1:0] REP_ONE  = REP_W'(1);
  logic [REP_W-1:0] rep_cnt_q;
`endif

  logic       any_low_d;
  logic [1:0] low_col_d;
  logic [1:0] row_idx_d;
  logic       slot_free_d;

  // Lowest active column wins; any_low flags that at least one column is low.
  always_comb begin
    any_low_d = ~&col_n;
    low_col_d = 2'd0;
    if (!col_n[0])      low_col_d = 2'd0;
    else if (!col_n[1]) low_col_d = 2'd1;
    else if (!col_n[2]) low_col_d = 2'd2;
    else if (!col_n[3]) low_col_d = 2'd3;
  end

  // Row index of the currently driven (low) row.
  always_comb begin
    case (row_n_q)
      4'b1101: row_idx_d = 2'd1;
      4'b1011: row_idx_d = 2'd2;
      4'b0111: row_idx_d = 2'd3;
      default: row_idx_d = 2'd0;
    endcase
  end

  // A new code may load when nothing is pending or the pending one is acked now.
  assign slot_free_d = ~valid_q | kbd_ack;

  // Scan / debounce FSM with registered outputs and the consumer handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= SCAN;
      scan_cnt_q <= '0;
      deb_cnt_q  <= '0;
      row_n_q    <= 4'b1110;
      cand_q     <= 4'h0;
      kbd_q      <= 4'h0;
      valid_q    <= 1'b0;
      key_down_q <= 1'b0;
`ifdef KBD_REPEAT_EN
      rep_cnt_q  <= '0;
`endif
    end else begin
      // Acknowledge first; a load later in this block overrides the clear.
      if (valid_q && kbd_ack) valid_q <= 1'b0;

      case (state_q)
        SCAN: begin
          if (scan_cnt_q == SCAN_LAST) begin
            scan_cnt_q <= '0;
            if (any_low_d) begin
              // Freeze on this row; the rotation is skipped on this edge.
              cand_q    <= {row_idx_d, low_col_d};
              deb_cnt_q <= '0;
              state_q   <= DEB_PRESS;
            end else begin
              row_n_q <= {row_n_q[2:0], row_n_q[3]};
            end
          end else begin
            scan_cnt_q <= scan_cnt_q + CNT_ONE;
          end
        end

        DEB_PRESS: begin
          if (deb_cnt_q == DEB_LAST) begin
            key_down_q <= 1'b1;
            deb_cnt_q  <= '0;
            state_q    <= HELD;
            if (slot_free_d) begin
              kbd_q   <= cand_q;
              valid_q <= 1'b1;
            end
`ifdef KBD_REPEAT_EN
            rep_cnt_q <= '0;
`endif
          end else if (any_low_d && (low_col_d == cand_q[1:0])) begin
            deb_cnt_q <= deb_cnt_q + CNT_ONE;
          end else begin
            // Bounce: go back to scanning from the frozen row, full dwell.
            deb_cnt_q <= '0;
            state_q   <= SCAN;
          end
        end

        HELD: begin
          deb_cnt_q <= '0;
          if (!any_low_d) state_q <= DEB_RELEASE;
`ifdef KBD_REPEAT_EN
          if (rep_cnt_q == REP_LAST) begin
            rep_cnt_q <= '0;
            if (slot_free_d) begin
              kbd_q   <= cand_q;
              valid_q <= 1'b1;
            end
          end else begin
            rep_cnt_q <= rep_cnt_q + REP_ONE;
          end
`endif
        end

        DEB_RELEASE: begin
          if (any_low_d) begin
            deb_cnt_q <= '0;
            state_q   <= HELD;
`ifdef KBD_REPEAT_EN
            rep_cnt_q <= '0;
`endif
          end else if (deb_cnt_q == DEB_LAST) begin
            // Release accepted; scanning restarts on the same row.
            key_down_q <= 1'b0;
            deb_cnt_q  <= '0;
            state_q    <= SCAN;
          end else begin
            deb_cnt_q <= deb_cnt_q + CNT_ONE;
          end
        end

        default: state_q <= SCAN;
      endcase
    end
  end

  assign row_n     = row_n_q;
  assign kbd       = kbd_q;
  assign kbd_valid = valid_q;
  assign key_down  = key_down_q;

endmodule

// File: tb/tb_kbd_scan_encoder.sv
// Bench for kbd_scan_encoder: a keypad model turns a pressed-key mask into
// col_n, a behavioural model predicts every output each cycle, and a few
// directed scenarios pin exact literal values.
module tb_kbd_scan_encoder;

  localparam int SD  = 4;
  localparam int DEB = 8;

  localparam int P_SCAN  = 0;
  localparam int P_PRESS = 1;
  localparam int P_HELD  = 2;
  localparam int P_REL   = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] row_n;
  logic [3:0] col_n;
  logic [3:0] kbd;
  logic       kbd_valid;
  logic       kbd_ack;
  logic       key_down;

  logic [15:0] keys;     // bit k set = key k physically pressed
  bit          cmp_en = 1'b0;

  int n_checks = 0;
  int n_err    = 0;

  kbd_scan_encoder #(.SCAN_DIV(SD), .DEB_CYCLES(DEB), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .row_n(row_n), .col_n(col_n),
    .kbd(kbd), .kbd_valid(kbd_valid), .kbd_ack(kbd_ack), .key_down(key_down)
  );

  always #5 clk = ~clk;

  // Keypad: a pressed key pulls its column low when its row is driven.
  always_comb begin
    col_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!row_n[r] && keys[r*4+c]) col_n[c] = 1'b0;
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_phase = P_SCAN, m_row = 0, m_dwell = 0, m_n = 0;
  int m_code = 0, m_col = 0, m_rep = 0, m_kbd = 0, m_lc = -1;
  bit m_valid = 1'b0, m_down = 1'b0;

  function automatic int lowest(logic [3:0] c);
    for (int i = 0; i < 4; i++) if (!c[i]) return i;
    return -1;
  endfunction

  task automatic offer(int code);
    if (!m_valid) begin
      m_kbd   = code;
      m_valid = 1'b1;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = P_SCAN; m_row = 0; m_dwell = 0; m_n = 0; m_code = 0;
      m_col = 0; m_rep = 0; m_kbd = 0; m_valid = 0; m_down = 0;
    end else begin
      m_lc = lowest(col_n);
      if (m_valid && kbd_ack) m_valid = 1'b0;
      case (m_phase)
        P_SCAN:
          if (m_dwell == SD - 1) begin
            m_dwell = 0;
            if (m_lc >= 0) begin
              m_code = m_row * 4 + m_lc; m_col = m_lc; m_n = 0; m_phase = P_PRESS;
            end else m_row = (m_row + 1) % 4;
          end else m_dwell++;
        P_PRESS:
          if (m_n == DEB) begin
            m_down = 1'b1; offer(m_code); m_n = 0; m_rep = 0; m_phase = P_HELD;
          end else if (m_lc == m_col) m_n++;
          else m_phase = P_SCAN;
        P_HELD: begin
`ifdef KBD_REPEAT_EN
          if (m_rep == 16 * SD - 1) begin m_rep = 0; offer(m_code); end
          else m_rep++;
`endif
          if (m_lc < 0) begin m_phase = P_REL; m_n = 0; end
        end
        default:
          if (m_lc >= 0) begin m_phase = P_HELD; m_rep = 0; end
          else if (m_n == DEB) begin m_down = 1'b0; m_phase = P_SCAN; end
          else m_n++;
      endcase
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en && rst_n) begin
      check("row_n", {28'd0, row_n}, {28'd0, 4'(~(4'b0001 << m_row))});
      check("kbd", {28'd0, kbd}, 32'(m_kbd));
      check("kbd_valid", {31'd0, kbd_valid}, {31'd0, m_valid});
      check("key_down", {31'd0, key_down}, {31'd0, m_down});
    end
  end

  // ---------------- bounded waits ----------------
  task automatic wait_valid(int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge clk);
      if (kbd_valid) break;
    end
    if (i == budget) begin
      n_checks++; n_err++;
      $display("FAIL wait_valid timeout after %0d cycles", budget);
    end
  endtask

  task automatic wait_down(bit lvl, int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge clk);
      if (key_down == lvl) break;
    end
    if (i == budget) begin
      n_checks++; n_err++;
      $display("FAIL wait_down(%0d) timeout after %0d cycles", lvl, budget);
    end
  endtask

  task automatic wait_phase(int ph, int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge clk);
      if (m_phase == ph) break;
    end
    if (i == budget) begin
      n_checks++; n_err++;
      $display("FAIL wait_phase(%0d) timeout after %0d cycles", ph, budget);
    end
  endtask

  task automatic ack_once();
    kbd_ack = 1'b1;
    @(negedge clk);
    kbd_ack = 1'b0;
  endtask

  logic [3:0] rowseq [4];
  int sel, hold, k1, k2;

  // ---------------- stimulus ----------------
  initial begin
    rowseq = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    rst_n = 1'b0; kbd_ack = 1'b0; keys = 16'h0;
    repeat (3) @(negedge clk);
    check("rst_row_n", {28'd0, row_n}, 32'h0000_000E);
    check("rst_kbd", {28'd0, kbd}, 32'h0);
    check("rst_valid", {31'd0, kbd_valid}, 32'h0);
    check("rst_key_down", {31'd0, key_down}, 32'h0);
    rst_n = 1'b1; cmp_en = 1'b1;

    // Idle scan: one row step every SD clocks.
    for (int k = 1; k <= 4; k++) begin
      repeat (SD) @(negedge clk);
      check("scan_row", {28'd0, row_n}, {28'd0, rowseq[k % 4]});
    end

    // Row 2 col 1 pressed at the start of row 0's dwell: detect on edge 12,
    // valid after DEB+1 more edges.
    keys = 16'h0200;
    repeat (12 + DEB) @(negedge clk);
    check("press_latency_pre", {31'd0, kbd_valid}, 32'h0);
    @(negedge clk);
    check("press_valid", {31'd0, kbd_valid}, 32'h1);
    check("press_code", {28'd0, kbd}, 32'h9);
    check("press_down", {31'd0, key_down}, 32'h1);
    ack_once();
    check("ack_clears", {31'd0, kbd_valid}, 32'h0);
    keys = 16'h0;
    wait_phase(P_SCAN, 200);

    // Bounce: 3-clock low/high toggling never yields a code.
    for (int i = 0; i < 24; i++) begin
      keys = ((i / 3) % 2 == 0) ? 16'h0040 : 16'h0000;
      @(negedge clk);
    end
    keys = 16'h0;
    repeat (2) @(negedge clk);
    check("bounce_no_valid", {31'd0, kbd_valid}, 32'h0);
    check("bounce_no_down", {31'd0, key_down}, 32'h0);

    // Two keys in row 3 (cols 0 and 2): lowest column wins.
    keys = 16'h5000;
    wait_valid(200);
    check("two_col_code", {28'd0, kbd}, 32'hC);
    ack_once();
    keys = 16'h0;
    wait_down(1'b0, 200);

    // Overrun: 0x5 unacked, then 0xA pressed; 0x5 must stay.
    keys = 16'h0020;
    wait_valid(200);
    check("ovr_first", {28'd0, kbd}, 32'h5);
    keys = 16'h0;
    wait_down(1'b0, 200);
    keys = 16'h0400;
    wait_down(1'b1, 200);
    check("ovr_kbd_kept", {28'd0, kbd}, 32'h5);
    check("ovr_valid_kept", {31'd0, kbd_valid}, 32'h1);
    ack_once();
    keys = 16'h0;
    wait_down(1'b0, 200);

    // Randomised presses, chords, bounces and acks.
    for (int it = 0; it < 150; it++) begin
      sel  = int'($urandom_range(0, 9));
      hold = int'($urandom_range(1, 60));
      k1   = int'($urandom_range(0, 15));
      k2   = int'($urandom_range(0, 15));
      for (int h = 0; h < hold; h++) begin
        if (sel < 5)       keys = 16'(1) << k1;
        else if (sel < 7)  keys = (16'(1) << k1) | (16'(1) << k2);
        else if (sel == 8) keys = ($urandom_range(0, 1) == 1) ? (16'(1) << k1) : 16'h0;
        else               keys = 16'h0;
        kbd_ack = ($urandom_range(0, 3) == 0);
        @(negedge clk);
      end
    end
    kbd_ack = 1'b0;
    keys = 16'h0;
    wait_down(1'b0, 200);
    if (kbd_valid) ack_once();

    // Asynchronous reset in the middle of a press debounce.
    keys = 16'h0008;
    wait_phase(P_PRESS, 200);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_row_n", {28'd0, row_n}, 32'hE);
    check("midrst_kbd", {28'd0, kbd}, 32'h0);
    check("midrst_valid", {31'd0, kbd_valid}, 32'h0);
    check("midrst_down", {31'd0, key_down}, 32'h0);
    @(negedge clk);
    keys = 16'h0;
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

`ifdef KBD_REPEAT_EN
    // Held key re-offers its code after 16*SD clocks in HELD.
    keys = 16'h0080;
    wait_valid(200);
    ack_once();
    check("rep_cleared", {31'd0, kbd_valid}, 32'h0);
    wait_valid(16 * SD + 4);
    check("rep_code", {28'd0, kbd}, 32'h7);
    ack_once();
    keys = 16'h0;
    wait_down(1'b0, 200);
`endif

    repeat (4) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
